// File: rtl/hdmi_axi_addr_gen.sv
// hdmi_axi_addr_gen: frame-buffer scan-out read-address generator feeding an AXI read master
//   clk, rst     : clock, synchronous active-high reset
//   frame_start  : vsync pulse; samples base_addr, primes line credits, aborts a running frame
//   base_addr    : frame buffer byte base address
//   line_req     : one pulse per displayed line start; grants one line credit
//   busy         : AXI read master busy; a command is accepted when busy is seen high while kicking
//   kick         : command valid, held until accepted
//   read_addr    : byte address of the current burst
//   read_num     : pixel count of the current burst
//   line_done    : pulse after the last burst of a line is accepted
//   frame_done   : pulse after the last line of a frame
//   credit_ovf   : sticky, line_req arrived with credits saturated; cleared by frame_start
//   Define HDMI_ADDR_VFLIP_EN to fetch lines bottom-up.
module hdmi_axi_addr_gen #(
    parameter int X_SIZE          = 1280,
    parameter int Y_SIZE          = 720,
    parameter int BURST_WORDS     = 64,
    parameter int BYTES_PER_PIXEL = 4,
    parameter int LINE_STRIDE     = X_SIZE * BYTES_PER_PIXEL,
    parameter int PREFETCH_LINES  = 2,
    parameter int MAX_CREDIT      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [31:0] base_addr,
    input  logic        line_req,
    input  logic        busy,
    output logic        kick,
    output logic [31:0] read_addr,
    output logic [31:0] read_num,
    output logic        line_done,
    output logic        frame_done,
    output logic        credit_ovf
);
    localparam int CW = $clog2(MAX_CREDIT + 1);
    typedef enum logic [2:0] {IDLE, LINE_WAIT, ARM, ISSUE, WAIT} state_t;
    state_t state, state_next;
    logic [11:0] x, y, rem, num;
    logic [CW-1:0] credit;
    logic [31:0] base, pend_base, row;
    logic pend, accept, start, pend_set, consume, grant;
    assign accept   = (state == WAIT) && busy;
    // a frame_start during ISSUE/WAIT is held pending until the in-flight command is accepted
    assign start    = (frame_start && (state == IDLE || state == LINE_WAIT || state == ARM)) ||
                      (accept && (pend || frame_start));
    assign pend_set = frame_start && !start;
    assign consume  = accept && !start && (x == 12'(X_SIZE));
    assign grant    = line_req && (state != IDLE);
    assign kick     = (state == ISSUE) || (state == WAIT);
    assign rem      = 12'(X_SIZE) - x;
    assign num      = (rem < 12'(BURST_WORDS)) ? rem : 12'(BURST_WORDS);
`ifdef HDMI_ADDR_VFLIP_EN
    assign row = 32'(Y_SIZE - 1) - {20'd0, y};
`else
    assign row = {20'd0, y};
`endif
    always_comb begin
        state_next = state;
        if (start)
            state_next = LINE_WAIT;
        else
            case (state)
                LINE_WAIT: state_next = (y == 12'(Y_SIZE)) ? IDLE : ((credit != '0) ? ARM : LINE_WAIT);
                ARM:       state_next = busy ? ARM : ISSUE;
                ISSUE:     state_next = WAIT;
                WAIT:      state_next = !busy ? WAIT : ((x == 12'(X_SIZE)) ? LINE_WAIT : ARM);
                default:   state_next = IDLE;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            read_addr  <= '0;
            read_num   <= 32'(BURST_WORDS);
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            credit_ovf <= 1'b0;
            x          <= '0;
            y          <= '0;
            credit     <= '0;
            base       <= '0;
            pend_base  <= '0;
            pend       <= 1'b0;
        end else begin
            line_done  <= consume;
            frame_done <= !start && (state == LINE_WAIT) && (y == 12'(Y_SIZE));
            if (frame_start)
                credit_ovf <= 1'b0;
            else if (grant && !consume && (credit == CW'(MAX_CREDIT)))
                credit_ovf <= 1'b1;
            if (start) begin
                base   <= (pend && !frame_start) ? pend_base : base_addr;
                pend   <= 1'b0;
                x      <= '0;
                y      <= '0;
                credit <= CW'(PREFETCH_LINES);
            end else begin
                if (pend_set) begin
                    pend      <= 1'b1;
                    pend_base <= base_addr;
                end
                if (state == ARM && !busy) begin
                    read_addr <= base + row * 32'(LINE_STRIDE) + {20'd0, x} * 32'(BYTES_PER_PIXEL);
                    read_num  <= {20'd0, num};
                end
                if (state == ISSUE)
                    x <= x + read_num[11:0];
                if (consume) begin
                    x <= '0;
                    y <= y + 12'd1;
                end
                if (grant && !consume && (credit != CW'(MAX_CREDIT)))
                    credit <= credit + CW'(1);
                else if (consume && !grant)
                    credit <= credit - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hdmi_axi_addr_gen.sv
// tb_hdmi_axi_addr_gen: scoreboard bench for hdmi_axi_addr_gen with a frame-level reference model
module tb_hdmi_axi_addr_gen;
    localparam int X = 200, Y = 4, BW = 64, BPP = 4, STRIDE = X * BPP, PF = 2, MC = 4;
    localparam int K_CMD = 0, K_LINE = 1, K_FRAME = 2;
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] num;
    } ev_t;
    logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, line_req = 1'b0, busy = 1'b0;
    logic [31:0] base_addr = '0;
    logic kick, line_done, frame_done, credit_ovf;
    logic [31:0] read_addr, read_num;
    ev_t exp_q[$];
    int tests = 0, fails = 0, cmd_seen = 0, stall_at = 32'h7fff_ffff;
    bit stall = 1'b0;

    hdmi_axi_addr_gen #(
        .X_SIZE(X), .Y_SIZE(Y), .BURST_WORDS(BW), .BYTES_PER_PIXEL(BPP),
        .LINE_STRIDE(STRIDE), .PREFETCH_LINES(PF), .MAX_CREDIT(MC)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .base_addr(base_addr),
        .line_req(line_req), .busy(busy), .kick(kick), .read_addr(read_addr),
        .read_num(read_num), .line_done(line_done), .frame_done(frame_done),
        .credit_ovf(credit_ovf)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        return (k == K_CMD) ? "cmd" : ((k == K_LINE) ? "line_done" : "frame_done");
    endfunction

    // whole-frame expectation: every line split into BW-pixel chunks, then line/frame markers
    function automatic void push_frame(input logic [31:0] b);
        for (int yy = 0; yy < Y; yy++) begin
            int row;
            ev_t e;
`ifdef HDMI_ADDR_VFLIP_EN
            row = Y - 1 - yy;
`else
            row = yy;
`endif
            for (int xx = 0; xx < X; xx += BW) begin
                e.kind = K_CMD;
                e.addr = b + 32'(row * STRIDE) + 32'(xx * BPP);
                e.num  = 32'((X - xx < BW) ? X - xx : BW);
                exp_q.push_back(e);
            end
            e.kind = K_LINE;
            exp_q.push_back(e);
        end
        begin
            ev_t f;
            f.kind = K_FRAME;
            f.addr = '0;
            f.num  = '0;
            exp_q.push_back(f);
        end
    endfunction

    task automatic check_ev(input int k);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL ev_unexpected: got %s, required no event", kname(k));
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k) begin
                fails++;
                $display("FAIL ev_order: got %s, required %s", kname(k), kname(e.kind));
            end else if (k == K_CMD && (read_addr !== e.addr || read_num !== e.num)) begin
                fails++;
                $display("FAIL cmd%0d: got addr %h num %0d, required addr %h num %0d",
                         cmd_seen, read_addr, read_num, e.addr, e.num);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] b);
        base_addr   = b;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        base_addr   = $urandom();
        #1;
        exp_q.delete();
        push_frame(b);
    endtask

    task automatic wait_drain(input string name, input bit feed, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            line_req = feed && (n % 30 == 29);
            tick();
            n++;
        end
        line_req = 1'b0;
        chk(name, 32'(exp_q.size()), 0);
    endtask

    // monitor: a rising kick is a new command; pulses are popped in arrival order
    initial begin
        logic kick_q;
        kick_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst)
                kick_q = 1'b0;
            else begin
                if (kick && !kick_q) begin
                    cmd_seen++;
                    check_ev(K_CMD);
                end
                if (line_done)
                    check_ev(K_LINE);
                if (frame_done)
                    check_ev(K_FRAME);
                kick_q = kick;
            end
        end
    end

    // AXI master stand-in: random latency, random busy length, can be held off
    initial forever begin
        @(posedge clk);
        #1;
        if (kick) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            while (stall || cmd_seen >= stall_at) @(posedge clk);
            #1 busy = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 busy = 1'b0;
        end
    end

    initial begin
        int c0, lows;
        repeat (3) tick();
        chk("rst_kick", 32'(kick), 0);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_read_num", read_num, BW);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_credit_ovf", 32'(credit_ovf), 0);
        rst = 1'b0;
        tick();

        start_frame(32'h1000_0000);
        wait_drain("frame0_drain", 1'b1, 2000);

        c0 = cmd_seen;
        start_frame(32'h2000_0000);
        for (int i = 0; i < 400 && cmd_seen - c0 < 8; i++) tick();
        repeat (60) tick();
        chk("stall_cmds", 32'(cmd_seen - c0), 8);
        chk("stall_kick", 32'(kick), 0);
        chk("stall_pending", 32'(exp_q.size()), 11);
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        repeat (100) tick();
        chk("credit_line3", 32'(cmd_seen - c0), 12);
        wait_drain("stall_drain", 1'b1, 2000);

        stall = 1'b1;
        start_frame($urandom());
        for (int i = 0; i < 6; i++) begin
            line_req = 1'b1;
            tick();
            line_req = 1'b0;
            tick();
            if (i == 1)
                chk("ovf_at_max", 32'(credit_ovf), 0);
        end
        chk("ovf_set", 32'(credit_ovf), 1);
        stall = 1'b0;
        wait_drain("ovf_drain", 1'b0, 2000);
        chk("ovf_sticky", 32'(credit_ovf), 1);
        start_frame($urandom());
        chk("ovf_clear", 32'(credit_ovf), 0);
        wait_drain("ovf2_drain", 1'b1, 2000);

        c0 = cmd_seen;
        stall_at = c0 + 4;
        start_frame(32'h3000_0000);
        for (int i = 0; i < 300 && cmd_seen < stall_at; i++) tick();
        repeat (3) tick();
        start_frame(32'h4000_0000);
        lows = 0;
        repeat (10) begin
            if (!kick)
                lows++;
            tick();
        end
        chk("abort_kick_held", 32'(lows), 0);
        chk("abort_no_new_cmd", 32'(cmd_seen - c0), 4);
        stall_at = 32'h7fff_ffff;
        wait_drain("abort_drain", 1'b1, 2000);

        for (int f = 0; f < 6; f++) begin
            start_frame($urandom());
            if (f % 2 == 1) begin
                repeat ($urandom_range(1, 80)) begin
                    line_req = ($urandom_range(0, 19) == 0);
                    tick();
                end
                line_req = 1'b0;
                start_frame($urandom());
            end
            wait_drain("rand_drain", 1'b1, 3000);
        end

        stall = 1'b1;
        start_frame(32'h5000_0000);
        for (int i = 0; i < 100 && !kick; i++) tick();
        repeat (2) tick();
        chk("pre_rst_kick", 32'(kick), 1);
        rst = 1'b1;
        tick();
        chk("rst_drop_kick", 32'(kick), 0);
        chk("rst_no_line_done", 32'(line_done), 0);
        chk("rst_read_addr2", read_addr, 0);
        rst = 1'b0;
        exp_q.delete();
        stall = 1'b0;
        repeat (10) tick();
        start_frame(32'h6000_0000);
        wait_drain("post_rst_drain", 1'b1, 2000);
        repeat (20) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
